// File: rtl/microseq.sv
// Microcode sequencer: fetches one micro-op per cycle from an external ROM,
// dispatches on {mode, opcode} through an external label table, and supports
// conditional branches plus call/return on a small internal stack.
module microseq #(
    parameter int unsigned CTRL_W = 32,
    parameter int unsigned UPC_W  = 10,
    parameter int unsigned OP_W   = 8,
    parameter int unsigned MODE_W = 1,
    parameter int unsigned NCOND  = 8,
    parameter int unsigned STK_D  = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [MODE_W-1:0]      mode,
    input  logic [OP_W-1:0]        opcode,
    input  logic [NCOND-1:0]       cond,
    input  logic                   mc__stall,
    input  logic                   err_clr,
    output logic [UPC_W-1:0]       rom_addr,
    input  logic [CTRL_W-1:0]      rom_data,
    output logic [MODE_W+OP_W-1:0] disp_addr,
    input  logic [UPC_W:0]         disp_data,
    output logic [CTRL_W-1:0]      mc__control,
    output logic                   mc__more,
    output logic [UPC_W-1:0]       mc__upc,
    output logic                   mc__dispatch,
    output logic                   mc__illegal,
    output logic [1:0]             mc__err
);

    localparam int unsigned CS_W = $clog2(NCOND);
    localparam int unsigned SP_W = $clog2(STK_D + 1);

    localparam logic [1:0] SeqNext   = 2'b00;
    localparam logic [1:0] SeqBranch = 2'b01;
    localparam logic [1:0] SeqCall   = 2'b10;
    localparam logic [1:0] SeqReturn = 2'b11;

    // Architectural state
    logic [CTRL_W-1:0] op_q, op_d;
    logic [UPC_W-1:0]  upc_q, upc_d;
    logic              bubble_q, bubble_d;
    logic              dispatch_q, dispatch_d;
    logic              illegal_q, illegal_d;
    logic [1:0]        err_q, err_d;
    logic [UPC_W-1:0]  stack_q [STK_D];
    logic [UPC_W-1:0]  stack_d [STK_D];
    logic [SP_W-1:0]   sp_q, sp_d;

    // Decoded fields of the current (held) micro-op
    logic              op_more;
    logic [1:0]        op_seq;
    logic [CS_W-1:0]   op_csel;
    logic [UPC_W-1:0]  op_target;

    // Sequencing decisions
    logic [UPC_W-1:0]  upc_inc;
    logic [UPC_W-1:0]  pop_val;
    logic [UPC_W-1:0]  next_upc;
    logic [UPC_W-1:0]  disp_entry;
    logic              disp_valid;
    logic              take_disp;
    logic              do_push;
    logic              do_pop;
    logic              ovf;
    logic              unf;

    assign op_more    = op_q[0];
    assign op_seq     = op_q[2:1];
    assign op_csel    = op_q[3 +: CS_W];
    assign op_target  = op_q[3 + CS_W +: UPC_W];

    assign upc_inc    = upc_q + UPC_W'(1);
    assign disp_addr  = {mode, opcode};
    assign disp_entry = disp_data[UPC_W-1:0];
    assign disp_valid = disp_data[UPC_W];

    // Top-of-stack read; index by compare so sp can range 0..STK_D without an
    // out-of-range array access.
    always_comb begin
        pop_val = '0;
        for (int unsigned i = 0; i < STK_D; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                pop_val = stack_q[i];
            end
        end
    end

    // Next micro-PC selection from the current op and the condition inputs
    always_comb begin
        take_disp = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        ovf       = 1'b0;
        unf       = 1'b0;
        next_upc  = upc_inc;
        case (op_seq)
            SeqNext: begin
                take_disp = ~op_more;
            end
            SeqBranch: begin
                if (cond[op_csel]) begin
                    next_upc = op_target;
                end else begin
                    take_disp = ~op_more;
                end
            end
            SeqCall: begin
                // A full stack drops the return address but still takes the jump
                next_upc = op_target;
                if (sp_q == SP_W'(STK_D)) begin
                    ovf = 1'b1;
                end else begin
                    do_push = 1'b1;
                end
            end
            SeqReturn: begin
                if (sp_q == '0) begin
                    unf       = 1'b1;
                    take_disp = 1'b1;
                end else begin
                    do_pop   = 1'b1;
                    next_upc = pop_val;
                end
            end
            default: begin
                take_disp = 1'b1;
            end
        endcase
        if (take_disp) begin
            next_upc = disp_entry;
        end
    end

    assign rom_addr = next_upc;

    // Register next-state: advance, or hold and bubble while stalled
    always_comb begin
        op_d       = op_q;
        upc_d      = upc_q;
        bubble_d   = 1'b1;
        dispatch_d = 1'b0;
        illegal_d  = 1'b0;
        sp_d       = sp_q;
        stack_d    = stack_q;
        err_d      = err_clr ? 2'b00 : err_q;
        if (!mc__stall) begin
            bubble_d   = 1'b0;
            dispatch_d = take_disp;
            // A fresh error on this edge overrides a simultaneous clear
            err_d      = err_d | {unf, ovf};
            if (take_disp && !disp_valid) begin
                // Illegal opcode: issue a null op; it dispatches again next cycle
                op_d      = '0;
                upc_d     = disp_entry;
                illegal_d = 1'b1;
            end else begin
                op_d  = rom_data;
                upc_d = next_upc;
                if (do_push) begin
                    for (int unsigned i = 0; i < STK_D; i++) begin
                        if (sp_q == SP_W'(i)) begin
                            stack_d[i] = upc_inc;
                        end
                    end
                    sp_d = sp_q + SP_W'(1);
                end else if (do_pop) begin
                    sp_d = sp_q - SP_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_q       <= '0;
            upc_q      <= '0;
            bubble_q   <= 1'b0;
            dispatch_q <= 1'b0;
            illegal_q  <= 1'b0;
            err_q      <= 2'b00;
            sp_q       <= '0;
            for (int unsigned i = 0; i < STK_D; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            op_q       <= op_d;
            upc_q      <= upc_d;
            bubble_q   <= bubble_d;
            dispatch_q <= dispatch_d;
            illegal_q  <= illegal_d;
            err_q      <= err_d;
            sp_q       <= sp_d;
            stack_q    <= stack_d;
        end
    end

    // A bubble keeps only the 'more' bit so the datapath sees a no-op
    assign mc__control  = bubble_q ? {{(CTRL_W-1){1'b0}}, op_q[0]} : op_q;
    assign mc__more     = op_q[0];
    assign mc__upc      = upc_q;
    assign mc__dispatch = dispatch_q;
    assign mc__illegal  = illegal_q;
    assign mc__err      = err_q;

endmodule

// File: tb/tb_microseq.sv
// Self-checking bench for microseq: directed scenarios plus a randomized run
// against a queue-based reference model of the sequencing rules.
module tb_microseq;

    localparam int CTRL_W = 32;
    localparam int UPC_W  = 10;
    localparam int OP_W   = 8;
    localparam int MODE_W = 1;
    localparam int NCOND  = 8;
    localparam int STK_D  = 4;

    logic                   clk = 1'b0;
    logic                   rst_b = 1'b0;
    logic [MODE_W-1:0]      mode;
    logic [OP_W-1:0]        opcode;
    logic [NCOND-1:0]       cond;
    logic                   stall;
    logic                   err_clr;
    logic [UPC_W-1:0]       rom_addr;
    logic [CTRL_W-1:0]      rom_data;
    logic [MODE_W+OP_W-1:0] disp_addr;
    logic [UPC_W:0]         disp_data;
    logic [CTRL_W-1:0]      mc_control;
    logic                   mc_more;
    logic [UPC_W-1:0]       mc_upc;
    logic                   mc_dispatch;
    logic                   mc_illegal;
    logic [1:0]             mc_err;

    logic [CTRL_W-1:0] rom  [1024];
    logic [UPC_W:0]    disp [512];

    assign rom_data  = rom[rom_addr];
    assign disp_data = disp[disp_addr];

    always #5 clk = ~clk;

    microseq dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .mode         (mode),
        .opcode       (opcode),
        .cond         (cond),
        .mc__stall    (stall),
        .err_clr      (err_clr),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .mc__control  (mc_control),
        .mc__more     (mc_more),
        .mc__upc      (mc_upc),
        .mc__dispatch (mc_dispatch),
        .mc__illegal  (mc_illegal),
        .mc__err      (mc_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_op;
    logic [9:0]  m_upc;
    bit          m_bub, m_dsp, m_ill;
    logic [1:0]  m_err;
    logic [9:0]  m_stk [$];

    function automatic logic [31:0] mkop(bit more, logic [1:0] sq, logic [2:0] cs,
                                         logic [9:0] tgt);
        return {16'h0, tgt, cs, sq, more};
    endfunction

    function automatic logic [31:0] exp_ctrl();
        return m_bub ? {31'b0, m_op[0]} : m_op;
    endfunction

    task automatic model_reset();
        m_op  = '0;
        m_upc = '0;
        m_bub = 1'b0;
        m_dsp = 1'b0;
        m_ill = 1'b0;
        m_err = 2'b00;
        m_stk.delete();
    endtask

    // Apply the sequencing rules for one clock edge using current inputs
    task automatic model_edge();
        logic [9:0]  nxt;
        logic [10:0] dd;
        logic [1:0]  e;
        bit          use_d;
        e = err_clr ? 2'b00 : m_err;
        if (stall) begin
            m_bub = 1'b1;
            m_dsp = 1'b0;
            m_ill = 1'b0;
            m_err = e;
            return;
        end
        use_d = 1'b0;
        nxt   = m_upc + 10'd1;
        case (m_op[2:1])
            2'd0: use_d = !m_op[0];
            2'd1: begin
                if (cond[m_op[5:3]]) nxt = m_op[15:6];
                else use_d = !m_op[0];
            end
            2'd2: begin
                if (m_stk.size() < STK_D) m_stk.push_back(m_upc + 10'd1);
                else e[0] = 1'b1;
                nxt = m_op[15:6];
            end
            default: begin
                if (m_stk.size() == 0) begin
                    e[1]  = 1'b1;
                    use_d = 1'b1;
                end else begin
                    nxt = m_stk.pop_back();
                end
            end
        endcase
        m_bub = 1'b0;
        m_err = e;
        m_dsp = use_d;
        m_ill = 1'b0;
        if (use_d) begin
            dd  = disp[{mode, opcode}];
            nxt = dd[9:0];
            if (!dd[10]) begin
                m_op  = '0;
                m_upc = nxt;
                m_ill = 1'b1;
                return;
            end
        end
        m_op  = rom[nxt];
        m_upc = nxt;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_b = 1'b0;
        model_reset();
        #2;
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_chk += 6;
        if (mc_control !== 32'h0) begin
            n_fail++; $display("FAIL reset_control: got %h expected 0", mc_control);
        end
        if (mc_upc !== 10'h0) begin
            n_fail++; $display("FAIL reset_upc: got %h expected 0", mc_upc);
        end
        if (mc_dispatch !== 1'b0) begin
            n_fail++; $display("FAIL reset_dispatch: got %b expected 0", mc_dispatch);
        end
        if (mc_illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal: got %b expected 0", mc_illegal);
        end
        if (mc_err !== 2'b00) begin
            n_fail++; $display("FAIL reset_err: got %b expected 00", mc_err);
        end
        if (rom_addr !== 10'h040) begin
            n_fail++; $display("FAIL reset_rom_addr: got %h expected 040", rom_addr);
        end
        #1;
        rst_b = 1'b1;
    endtask

    task automatic test_branch();
        rom[10'h040] = mkop(1'b1, 2'd1, 3'd3, 10'h100);
        cond = 8'h08;
        tick();
        n_chk += 3;
        if (mc_upc !== 10'h040) begin
            n_fail++; $display("FAIL disp_upc: got %h expected 040", mc_upc);
        end
        if (mc_dispatch !== 1'b1) begin
            n_fail++; $display("FAIL disp_flag: got %b expected 1", mc_dispatch);
        end
        if (mc_control !== rom[10'h040]) begin
            n_fail++; $display("FAIL disp_control: got %h expected %h", mc_control, rom[10'h040]);
        end
        tick();
        n_chk += 2;
        if (mc_upc !== 10'h100) begin
            n_fail++; $display("FAIL branch_taken: got %h expected 100", mc_upc);
        end
        if (mc_dispatch !== 1'b0) begin
            n_fail++; $display("FAIL branch_dispflag: got %b expected 0", mc_dispatch);
        end
        cond = 8'hF7;
        tick();
        tick();
        n_chk++;
        if (mc_upc !== 10'h041) begin
            n_fail++; $display("FAIL branch_not_taken: got %h expected 041", mc_upc);
        end
    endtask

    task automatic test_call_return();
        logic [9:0] exp_upc [4];
        exp_upc = '{10'h050, 10'h200, 10'h201, 10'h051};
        disp[9'h006] = {1'b1, 10'h050};
        rom[10'h050] = mkop(1'b1, 2'd2, 3'd0, 10'h200);
        rom[10'h200] = mkop(1'b1, 2'd0, 3'd0, 10'h000);
        rom[10'h201] = mkop(1'b0, 2'd3, 3'd0, 10'h000);
        opcode = 8'h06;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (mc_upc !== exp_upc[i]) begin
                n_fail++; $display("FAIL call_ret_upc[%0d]: got %h expected %h", i, mc_upc, exp_upc[i]);
            end
        end
        n_chk++;
        if (mc_err !== 2'b00) begin
            n_fail++; $display("FAIL call_ret_err: got %b expected 00", mc_err);
        end
    endtask

    task automatic test_stack_errors();
        logic [9:0] exp_upc [11];
        logic [1:0] exp_err [11];
        exp_upc = '{10'h300, 10'h310, 10'h320, 10'h330, 10'h340, 10'h350,
                    10'h331, 10'h321, 10'h311, 10'h301, 10'h300};
        exp_err = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                    2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
        disp[9'h007] = {1'b1, 10'h300};
        for (int k = 0; k < 5; k++) begin
            rom[10'h300 + 10'(k * 16)] = mkop(1'b1, 2'd2, 3'd0, 10'h310 + 10'(k * 16));
        end
        rom[10'h350] = mkop(1'b0, 2'd3, 3'd0, 10'h000);
        for (int k = 0; k < 4; k++) begin
            rom[10'h301 + 10'(k * 16)] = mkop(1'b0, 2'd3, 3'd0, 10'h000);
        end
        opcode = 8'h07;
        for (int i = 0; i < 11; i++) begin
            tick();
            n_chk += 2;
            if (mc_upc !== exp_upc[i]) begin
                n_fail++; $display("FAIL stack_upc[%0d]: got %h expected %h", i, mc_upc, exp_upc[i]);
            end
            if (mc_err !== exp_err[i]) begin
                n_fail++; $display("FAIL stack_err[%0d]: got %b expected %b", i, mc_err, exp_err[i]);
            end
        end
        n_chk++;
        if (mc_dispatch !== 1'b1) begin
            n_fail++; $display("FAIL underflow_dispatch: got %b expected 1", mc_dispatch);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_chk++;
        if (mc_err !== 2'b00) begin
            n_fail++; $display("FAIL err_clr: got %b expected 00", mc_err);
        end
        // Reset mid-call: a leftover stack entry would overflow on the 4th call
        apply_reset();
        n_chk++;
        if (mc_upc !== 10'h0 || mc_err !== 2'b00) begin
            n_fail++; $display("FAIL midcall_reset: got upc %h err %b expected 000 00", mc_upc, mc_err);
        end
        for (int i = 0; i < 5; i++) tick();
        n_chk++;
        if (mc_upc !== 10'h340 || mc_err !== 2'b00) begin
            n_fail++; $display("FAIL stack_discard: got upc %h err %b expected 340 00", mc_upc, mc_err);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        disp[9'h008] = {1'b1, 10'h060};
        for (int i = 0; i < 16; i++) begin
            rom[10'h060 + 10'(i)] = mkop(1'b1, 2'd0, 3'd0, 10'h000) | {16'($urandom), 16'h0};
        end
        opcode = 8'h08;
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk += 2;
            if (mc_control !== 32'h1) begin
                n_fail++; $display("FAIL stall_bubble[%0d]: got %h expected 1", i, mc_control);
            end
            if (mc_upc !== 10'h061) begin
                n_fail++; $display("FAIL stall_upc[%0d]: got %h expected 061", i, mc_upc);
            end
        end
        stall = 1'b0;
        tick();
        n_chk += 2;
        if (mc_upc !== 10'h062) begin
            n_fail++; $display("FAIL stall_resume_upc: got %h expected 062", mc_upc);
        end
        if (mc_control !== rom[10'h062]) begin
            n_fail++; $display("FAIL stall_resume_ctrl: got %h expected %h", mc_control, rom[10'h062]);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        disp[9'h009] = {1'b0, 10'h0AB};
        opcode = 8'h09;
        tick();
        n_chk += 3;
        if (mc_illegal !== 1'b1) begin
            n_fail++; $display("FAIL illegal_pulse: got %b expected 1", mc_illegal);
        end
        if (mc_control !== 32'h0) begin
            n_fail++; $display("FAIL illegal_control: got %h expected 0", mc_control);
        end
        if (mc_upc !== 10'h0AB) begin
            n_fail++; $display("FAIL illegal_upc: got %h expected 0ab", mc_upc);
        end
        opcode = 8'h05;
        tick();
        n_chk += 2;
        if (mc_illegal !== 1'b0) begin
            n_fail++; $display("FAIL illegal_one_cycle: got %b expected 0", mc_illegal);
        end
        if (mc_upc !== 10'h040) begin
            n_fail++; $display("FAIL illegal_recover: got %h expected 040", mc_upc);
        end
        // New error on the same edge as err_clr must stay set
        apply_reset();
        disp[9'h00A] = {1'b1, 10'h0C0};
        rom[10'h0C0] = mkop(1'b0, 2'd3, 3'd0, 10'h000);
        opcode = 8'h0A;
        cond   = 8'h00;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_chk++;
        if (mc_err !== 2'b10) begin
            n_fail++; $display("FAIL err_wins_clr: got %b expected 10", mc_err);
        end
        opcode = 8'h05;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_chk++;
        if (mc_err !== 2'b00 || mc_upc !== 10'h041) begin
            n_fail++; $display("FAIL err_clr_after: got err %b upc %h expected 00 041", mc_err, mc_upc);
        end
    endtask

    task automatic test_random();
        logic [46:0] obs, expv;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        for (int i = 0; i < 512; i++) disp[i] = {($urandom_range(0, 9) != 0), 10'($urandom)};
        for (int n = 0; n < 3000; n++) begin
            cond    = 8'($urandom);
            stall   = ($urandom_range(0, 4) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                opcode = 8'($urandom);
                mode   = 1'($urandom);
            end
            if ($urandom_range(0, 499) == 0) apply_reset();
            else tick();
            obs  = {mc_control, mc_more, mc_upc, mc_dispatch, mc_illegal, mc_err};
            expv = {exp_ctrl(), m_op[0], m_upc, m_dsp, m_ill, m_err};
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random[%0d]: got ctrl %h upc %h d%b i%b e%b expected ctrl %h upc %h d%b i%b e%b",
                         n, mc_control, mc_upc, mc_dispatch, mc_illegal, mc_err,
                         exp_ctrl(), m_upc, m_dsp, m_ill, m_err);
            end
        end
        stall   = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        for (int i = 0; i < 512; i++) disp[i] = {1'b1, 10'h000};
        disp[9'h005] = {1'b1, 10'h040};
        mode    = 1'b0;
        opcode  = 8'h05;
        cond    = 8'h00;
        stall   = 1'b0;
        err_clr = 1'b0;
        rst_b   = 1'b0;
        model_reset();
        test_reset();
        test_branch();
        test_call_return();
        test_stack_errors();
        test_stall();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
